host_bus_bridge: RTL
====================

HOST_BUS_BRIDGE -- requirements
Module: host_bus_bridge

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 2, port-select (mode) width.
- DATA_W, default 8, bus data width.
- FILTER_LEN, default 3, consecutive equal samples needed to accept a pin change (range 1..15).
- FIFO_DEPTH, default 4, write FIFO entries (power of 2, at least 2).

REQ-002 Ports SHALL be:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- csr_n  in  1  host read strobe (asynchronous pin).
- csw_n  in  1  host write strobe (asynchronous pin).
- mode  in  ADDR_W  host port select (asynchronous pin).
- cd_in  in  DATA_W  host data bus input.
- cd_out  out  DATA_W  read data to host.
- cd_oe  out  1  host bus output enable.
- vdp_req  out  1  request to core.
- vdp_wrt  out  1  1 = write, 0 = read.
- vdp_adr  out  ADDR_W  core port address.
- vdp_dbo  out  DATA_W  write data to core.
- vdp_dbi  in  DATA_W  read data from core.
- vdp_ack  in  1  core accepts request.
- fifo_level  out  log2(FIFO_DEPTH)+1  occupied write-FIFO entries.
- overflow  out  1  sticky lost-access flag.
- conflict  out  1  sticky simultaneous-strobe flag.

Function
REQ-003 csr_n, csw_n, mode and cd_in SHALL each pass through a 2-flop synchroniser.
REQ-004 Each synchronised strobe SHALL feed a filter whose output changes only after FILTER_LEN consecutive clocks of the new value. Glitches shorter than FILTER_LEN clocks SHALL be ignored.
REQ-005 An access edge SHALL be a 1->0 transition of a filtered strobe. Latency from raw pin edge to detected edge SHALL be 2+FILTER_LEN clocks.
REQ-006 On a csw_n access edge with the FIFO not full, {synchronised mode, synchronised cd_in} SHALL be pushed on the next clock.
REQ-007 A write edge with the FIFO full SHALL be dropped and set overflow.
REQ-008 Both filtered strobes low together SHALL generate no access and SHALL set conflict. An edge on one strobe while the other is low is a conflict.
REQ-009 On a csr_n access edge, the mode value SHALL be latched and rd_pending set.
REQ-010 A read edge while rd_pending is set SHALL be dropped and set overflow.
REQ-011 The FSM SHALL have states IDLE, WR_REQ and RD_REQ.
- IDLE -> WR_REQ when the FIFO is non-empty; the head entry drives vdp_adr and vdp_dbo, vdp_wrt=1.
- IDLE -> RD_REQ when the FIFO is empty and rd_pending is set; vdp_wrt=0 and vdp_adr is the latched mode.
- Reads SHALL never overtake queued writes.
REQ-012 vdp_req SHALL be registered, asserted in WR_REQ/RD_REQ, and held with stable vdp_adr, vdp_dbo and vdp_wrt until a clock with vdp_ack=1.
REQ-013 The ack clock SHALL end the request as follows:
- In WR_REQ, pop the FIFO.
- In RD_REQ, capture vdp_dbi into rd_data and clear rd_pending.
- In both cases, go to IDLE, with vdp_req low for at least one clock.
REQ-014 vdp_ack while vdp_req=0 SHALL be ignored.
REQ-015 Latency from a write edge into an empty FIFO (FSM in IDLE) to vdp_req=1 SHALL be 2 clocks.
REQ-016 A simultaneous push and pop SHALL leave fifo_level unchanged. FIFO pointers SHALL wrap modulo FIFO_DEPTH. fifo_level SHALL equal pushes minus pops, range 0..FIFO_DEPTH.
REQ-017 cd_out SHALL equal rd_data, which holds the last acknowledged read value.
REQ-018 cd_oe SHALL be the registered inverse of the synchronised (unfiltered) csr_n.
REQ-019 overflow and conflict SHALL clear only on reset.

Reset
REQ-020 On reset_n=0, asynchronously:
- FSM to IDLE.
- FIFO emptied (fifo_level=0).
- rd_pending=0; rd_data=0.
- vdp_req=0, vdp_wrt=0, vdp_adr=0, vdp_dbo=0.
- cd_oe=0; overflow=0; conflict=0.
- Synchroniser and filter outputs preset to 1.
REQ-021 Reset asserted mid-request SHALL drop vdp_req immediately and discard queued writes.
REQ-022 After reset release, strobes held low SHALL NOT produce an access until they have gone high and then low again through the filter.

Verification
REQ-023 With defaults, csw_n low for 10 clocks, mode=1, cd_in=0x87, ack 3 clocks after vdp_req: exactly one request with vdp_wrt=1, vdp_adr=1, vdp_dbo=0x87, held 3 clocks; fifo_level returns to 0.
REQ-024 csw_n low pulse of 2 clocks with FILTER_LEN=3: no push, vdp_req stays 0.
REQ-025 Six writes 0x01..0x06 with vdp_ack held 0: fifo_level reaches 4; writes 5 and 6 dropped; overflow=1; then ack every clock: exactly 0x01..0x04 issued in order.
REQ-026 Two writes queued, then a csr_n edge with mode=0, vdp_dbi=0x5A: both writes issued before the read; cd_out=0x5A after the read ack; cd_oe follows csr_n with 3-clock delay.
REQ-027 csr_n and csw_n driven low on the same clock: conflict=1, no request, FIFO unchanged.
REQ-028 reset_n pulsed low while vdp_req=1 with 3 entries queued: vdp_req=0 within the same clock, fifo_level=0, and no further request follows after release.

Source files
------------

// File: rtl/host_bus_bridge.sv
// Host bus bridge: filters the asynchronous host strobes, queues writes in a small FIFO
// and issues one request at a time to the core over a req/ack handshake.
module host_bus_bridge #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 8,
  parameter int FILTER_LEN = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          csr_n,
  input  logic                          csw_n,
  input  logic [ADDR_W-1:0]             mode,
  input  logic [DATA_W-1:0]             cd_in,
  output logic [DATA_W-1:0]             cd_out,
  output logic                          cd_oe,
  output logic                          vdp_req,
  output logic                          vdp_wrt,
  output logic [ADDR_W-1:0]             vdp_adr,
  output logic [DATA_W-1:0]             vdp_dbo,
  input  logic [DATA_W-1:0]             vdp_dbi,
  input  logic                          vdp_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          conflict
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [3:0] FL_M1 = 4'(FILTER_LEN - 1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;

  // Index 0 is the read strobe, index 1 the write strobe.
  logic [1:0]        stb_s1, stb_s2, filt, filt_d, armed, fall;
  logic [3:0]        cnt [2];
  logic [1:0]        prime_q;
  logic [ADDR_W-1:0] mode_s1, mode_s2;
  logic [DATA_W-1:0] cd_s1, cd_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stb_s1  <= '1;
      stb_s2  <= '1;
      mode_s1 <= '1;
      mode_s2 <= '1;
      cd_s1   <= '1;
      cd_s2   <= '1;
      prime_q <= '0;
    end else begin
      stb_s1  <= {csw_n, csr_n};
      stb_s2  <= stb_s1;
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      cd_s1   <= cd_in;
      cd_s2   <= cd_s1;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  // A strobe is armed only once a real high sample has been seen with the filter high,
  // so a strobe held low through reset cannot look like an access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt   <= '1;
      filt_d <= '1;
      armed  <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (stb_s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == FL_M1) begin
          filt[i] <= stb_s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
        if (prime_q[1] && filt[i] && stb_s2[i]) armed[i] <= 1'b1;
      end
    end
  end

  logic rd_edge, wr_edge, both_low;
  assign fall     = filt_d & ~filt & armed;
  assign rd_edge  = fall[0] & filt[1];
  assign wr_edge  = fall[1] & filt[0];
  assign both_low = ~filt[0] & ~filt[1] & (|armed);

  // Handshake: vdp_req with vdp_wrt/vdp_adr/vdp_dbo is held stable until a clock where
  // vdp_req and vdp_ack are both 1; that clock completes the transfer.
  state_t state_q, state_d;
  logic   ack_en, push, pop, rd_done, fifo_full, fifo_empty;
  logic   rd_pending;
  logic [ADDR_W-1:0] rd_mode;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW:0]       wptr, rptr;
  logic [EW-1:0]     head;

  assign ack_en     = vdp_ack & vdp_req;
  assign fifo_level = wptr - rptr;
  assign fifo_full  = (fifo_level == DEPTH_L);
  assign fifo_empty = (fifo_level == '0);
  assign push       = wr_edge & ~fifo_full;
  assign pop        = ack_en && (state_q == WR_REQ);
  assign rd_done    = ack_en && (state_q == RD_REQ);
  assign head       = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {mode_s2, cd_s2};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      rd_pending <= 1'b0;
      rd_mode    <= '0;
      cd_out     <= '0;
      cd_oe      <= 1'b0;
      overflow   <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (rd_done) begin
        cd_out     <= vdp_dbi;
        rd_pending <= 1'b0;
      end
      if (rd_edge && !rd_pending) begin
        rd_pending <= 1'b1;
        rd_mode    <= mode_s2;
      end
      if ((wr_edge && fifo_full) || (rd_edge && rd_pending)) overflow <= 1'b1;
      if (both_low) conflict <= 1'b1;
      cd_oe <= ~stb_s2[0];
    end
  end

  logic              req_d, wrt_d;
  logic [ADDR_W-1:0] adr_d;
  logic [DATA_W-1:0] dbo_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      vdp_req <= 1'b0;
      vdp_wrt <= 1'b0;
      vdp_adr <= '0;
      vdp_dbo <= '0;
    end else begin
      state_q <= state_d;
      vdp_req <= req_d;
      vdp_wrt <= wrt_d;
      vdp_adr <= adr_d;
      vdp_dbo <= dbo_d;
    end
  end

  // Writes are checked first so a pending read never overtakes queued writes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty)     state_d = WR_REQ;
        else if (rd_pending) state_d = RD_REQ;
      end
      WR_REQ, RD_REQ: if (ack_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d = (state_d != IDLE);
    wrt_d = vdp_wrt;
    adr_d = vdp_adr;
    dbo_d = vdp_dbo;
    if (state_q == IDLE && state_d == WR_REQ) begin
      wrt_d = 1'b1;
      adr_d = head[EW-1:DATA_W];
      dbo_d = head[DATA_W-1:0];
    end else if (state_q == IDLE && state_d == RD_REQ) begin
      wrt_d = 1'b0;
      adr_d = rd_mode;
    end
  end

endmodule
